// File: rtl/volume_step_ctrl.sv
// Button-driven attenuation control: debounced up/down/mute with auto-repeat,
// saturating level, mute override, same code replicated on every channel.

module vsc_debounce #(
  parameter int DEBOUNCE_CYC = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  logic          s1, s2;
  logic [DW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with db
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) cnt <= '0;
      else if (cnt == DW'(DEBOUNCE_CYC - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else cnt <= cnt + DW'(1);
    end
  end
endmodule

module volume_step_ctrl #(
  parameter int VOL_W        = 8,
  parameter int NCH          = 2,
  parameter int STEP         = 16,
  parameter int VOL_MAX      = 240,
  parameter int VOL_INIT     = 240,
  parameter int DEBOUNCE_CYC = 10000,
  parameter int HOLD_CYC     = 5000000,
  parameter int REPEAT_CYC   = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up,
  input  logic                 down,
  input  logic                 mute,
  output logic [NCH*VOL_W-1:0] volume,
  output logic                 muted,
  output logic                 at_min,
  output logic                 at_max,
  output logic                 step_pulse
);
  localparam int NIN     = 3;
  localparam int LW      = VOL_W + 1;
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [LW-1:0] STEP_L = LW'(STEP);
  localparam logic [LW-1:0] VMAX_L = LW'(VOL_MAX);
  localparam logic [LW-1:0] LIM_L  = LW'(VOL_MAX - STEP);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [NIN-1:0] raw, db, ev, ev_q, rise_q;
  logic           cmd_up, cmd_dn, held;
  state_t         state;
  logic           dir;
  logic [CW-1:0]  cnt;
  logic [VOL_W-1:0] level;
  logic [LW-1:0]  lvl_ext, lvl_up, lvl_dn, lvl_nxt;
  logic           step_req, step_dn, muted_nxt;
  logic [NCH-1:0][VOL_W-1:0] vol_q;

  assign raw = {mute, down, up};

  vsc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db [NIN-1:0] (
    .clk(clk), .rst_n(rst_n), .raw(raw), .db(db)
  );

  // both buttons down cancels each other out
  assign cmd_up = db[0] & ~db[1];
  assign cmd_dn = db[1] & ~db[0];
  assign ev     = {db[2], cmd_dn, cmd_up};
  assign held   = dir ? cmd_dn : cmd_up;

  assign lvl_ext = {1'b0, level};
  assign lvl_up  = (lvl_ext < STEP_L) ? '0 : lvl_ext - STEP_L;
  assign lvl_dn  = (lvl_ext > LIM_L) ? VMAX_L : lvl_ext + STEP_L;

  always_comb begin
    step_req = 1'b0;
    step_dn  = dir;
    case (state)
      IDLE: begin
        if (rise_q[0] && cmd_up) begin
          step_req = 1'b1;
          step_dn  = 1'b0;
        end else if (rise_q[1] && cmd_dn) begin
          step_req = 1'b1;
          step_dn  = 1'b1;
        end
      end
      default: step_req = held && (cnt == '0);
    endcase
  end

  assign lvl_nxt   = step_req ? (step_dn ? lvl_dn : lvl_up) : lvl_ext;
  // a step always unmutes, even if a mute toggle lands in the same clock
  assign muted_nxt = step_req ? 1'b0 : (rise_q[2] ? ~muted : muted);

  // cnt holds remaining clocks minus one, so a step fires exactly HOLD_CYC / REPEAT_CYC apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q       <= '0;
      rise_q     <= '0;
      state      <= IDLE;
      dir        <= 1'b0;
      cnt        <= '0;
      level      <= VOL_W'(VOL_INIT);
      muted      <= 1'b0;
      step_pulse <= 1'b0;
      at_min     <= (VOL_INIT == 0);
      at_max     <= (VOL_INIT == VOL_MAX);
      vol_q      <= {NCH{VOL_W'(VOL_INIT)}};
    end else begin
      ev_q   <= ev;
      rise_q <= ev & ~ev_q;
      case (state)
        IDLE: if (step_req) begin
          dir   <= step_dn;
          cnt   <= CW'(HOLD_CYC - 1);
          state <= HOLD;
        end
        default: begin
          if (!held) state <= IDLE;
          else if (cnt == '0) begin
            cnt   <= CW'(REPEAT_CYC - 1);
            state <= REPEAT;
          end else cnt <= cnt - CW'(1);
        end
      endcase
      level      <= lvl_nxt[VOL_W-1:0];
      muted      <= muted_nxt;
      step_pulse <= step_req && (lvl_nxt != lvl_ext);
      at_min     <= (lvl_nxt == '0);
      at_max     <= (lvl_nxt == VMAX_L);
      vol_q      <= {NCH{muted_nxt ? VOL_W'(VOL_MAX) : lvl_nxt[VOL_W-1:0]}};
    end
  end

  assign volume = vol_q;
endmodule
